// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Operation encodings, FSM states and decode helpers for mdu_iter.
// Revision : 1.0
// ============================================================================
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_legal(input mdu_op_t op);
        return (4'(op) <= 4'd12);
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(input mdu_op_t op);
        case (op)
            OP_REM, OP_REMU, OP_REMW, OP_REMUW: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_word(input mdu_op_t op);
        case (op)
            OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_a(input mdu_op_t op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(input mdu_op_t op);
        case (op)
            OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_div_step.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_step
// Brief    : Combinational restoring-division step retiring STEP quotient bits.
// Revision : 1.0
// ============================================================================
module mdu_div_step #(
    parameter int XLEN = 64,
    parameter int STEP = 1
)(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    // One extra bit holds the shifted partial remainder; its top bit of the
    // trial difference doubles as the borrow flag.
    logic [XLEN:0]   w_r;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_q;

    always_comb begin
        w_r    = {1'b0, i_rem};
        w_q    = i_quo;
        w_diff = '0;
        for (int k = 0; k < STEP; k++) begin
            w_r    = {w_r[XLEN-1:0], w_q[XLEN-1]};
            w_q    = {w_q[XLEN-2:0], 1'b0};
            w_diff = w_r - {1'b0, i_divisor};
            if (!w_diff[XLEN]) begin
                w_r    = w_diff;
                w_q[0] = 1'b1;
            end
        end
        o_rem = w_r[XLEN-1:0];
        o_quo = w_q;
    end

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative RV64M multiply/divide unit, STEP bits per cycle.
// Revision : 1.0
// ============================================================================
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int STEP = 1
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  mdu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int c_n_full = XLEN / STEP;
    localparam int c_n_word = 32 / STEP;
    localparam int c_cnt_w  = $clog2(c_n_full);
    localparam logic [c_cnt_w-1:0] c_last_full = c_cnt_w'(c_n_full - 1);
    localparam logic [c_cnt_w-1:0] c_last_word = c_cnt_w'(c_n_word - 1);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0]     s;
        logic signed [XLEN-1:0] e;
        s = v;
        e = s;
        return e;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] e;
        e = v;
        return e;
    endfunction

    mdu_state_t        r_state, w_state_nx;
    mdu_op_t           r_op;
    logic              r_neg, r_neg_r;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2*XLEN-1:0] r_prod, r_mcand;
    logic [XLEN-1:0]   r_mplr, r_rem, r_quo, r_dvsr, r_result;

    logic              w_word, w_sa, w_sb, w_legal, w_dz, w_ovf, w_fast;
    logic              w_accept, w_last;
    logic [XLEN-1:0]   w_ea, w_eb, w_ma, w_mb, w_min, w_fast_res;
    logic [2*XLEN-1:0] w_mul_sum, w_prod_fix;
    logic [XLEN-1:0]   w_rem_nx, w_quo_nx, w_final;

    // Operand conditioning and fast-path decision at accept time.
    always_comb begin
        w_word  = is_word(op);
        w_legal = is_legal(op) && !(w_word && (XLEN == 32));
        w_ea    = w_word ? (is_signed_a(op) ? sext32(a[31:0]) : zext32(a[31:0])) : a;
        w_eb    = w_word ? (is_signed_b(op) ? sext32(b[31:0]) : zext32(b[31:0])) : b;
        w_sa    = is_signed_a(op) & w_ea[XLEN-1];
        w_sb    = is_signed_b(op) & w_eb[XLEN-1];
        w_ma    = w_sa ? -w_ea : w_ea;
        w_mb    = w_sb ? -w_eb : w_eb;
        w_min   = w_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        w_dz    = w_legal && is_div(op) && (w_eb == '0);
        w_ovf   = w_legal && is_div(op) && is_signed_a(op) && (w_ea == w_min) && (w_eb == '1);
        w_fast  = !w_legal || w_dz || w_ovf;

        if (!w_legal)
            w_fast_res = '0;
        else if (w_dz)
            w_fast_res = is_rem(op) ? w_ea : '1;
        else
            w_fast_res = is_rem(op) ? '0 : w_ea;
        if (w_word)
            w_fast_res = sext32(w_fast_res[31:0]);
    end

    always_comb begin
        w_mul_sum = r_prod;
        for (int k = 0; k < STEP; k++) begin
            if (r_mplr[k])
                w_mul_sum = w_mul_sum + (r_mcand << k);
        end
    end

    mdu_div_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dvsr),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    // Sign correction folds into the final iteration cycle.
    always_comb begin
        w_prod_fix = r_neg ? -w_mul_sum : w_mul_sum;
        case (r_op)
            OP_MULH, OP_MULHSU, OP_MULHU:
                w_final = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW:
                w_final = r_neg ? -w_quo_nx : w_quo_nx;
            OP_REM, OP_REMU, OP_REMW, OP_REMUW:
                w_final = r_neg_r ? -w_rem_nx : w_rem_nx;
            default:
                w_final = w_prod_fix[XLEN-1:0];
        endcase
        if (is_word(r_op))
            w_final = sext32(w_final[31:0]);
    end

    assign w_accept = (r_state == ST_IDLE) && in_valid && !flush;
    assign w_last   = (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nx = w_fast ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (flush)       w_state_nx = ST_IDLE;
                else if (w_last) w_state_nx = ST_DONE;
            end
            ST_DONE: if (flush || out_ready) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        busy      = (r_state != ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_neg   <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= w_word ? c_last_word : c_last_full;
            r_prod  <= '0;
            r_mcand <= {{XLEN{1'b0}}, w_ma};
            r_mplr  <= w_mb;
            r_rem   <= '0;
            // Word dividends are left-aligned so 32 steps consume exactly their bits.
            r_quo   <= w_word ? (w_ma << 32) : w_ma;
            r_dvsr  <= w_mb;
            if (w_fast)
                r_result <= w_fast_res;
        end else if ((r_state == ST_BUSY) && !flush) begin
            r_cnt   <= r_cnt - c_cnt_w'(1);
            r_prod  <= w_mul_sum;
            r_mcand <= r_mcand << STEP;
            r_mplr  <= r_mplr >> STEP;
            r_rem   <= w_rem_nx;
            r_quo   <= w_quo_nx;
            if (w_last)
                r_result <= w_final;
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Directed self-checking bench for mdu_iter (STEP=1 and STEP=4).
// Revision : 1.0
// ============================================================================
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    mdu_op_t     op;
    logic [63:0] a, b, result;
    logic        in_valid4, in_ready4, flush4, out_valid4, out_ready4, busy4;
    mdu_op_t     op4;
    logic [63:0] a4, b4, result4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(64), .STEP(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    mdu_iter #(.XLEN(64), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .op(op4), .a(a4), .b(b4), .flush(flush4), .out_valid(out_valid4),
        .out_ready(out_ready4), .result(result4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input bit s4, input mdu_op_t o, input logic [63:0] x, input logic [63:0] y);
        if (s4) begin
            in_valid4 = 1'b1; op4 = o; a4 = x; b4 = y;
        end else begin
            in_valid = 1'b1; op = o; a = x; b = y;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic wait_valid(input bit s4, output int lat);
        lat = 0;
        while (!(s4 ? out_valid4 : out_valid) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take(input bit s4);
        if (s4) out_ready4 = 1'b1;
        else    out_ready  = 1'b1;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        out_ready4 = 1'b0;
    endtask

    task automatic run(input bit s4, input string tag, input mdu_op_t o,
                       input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp, input int exp_lat);
        int lat;
        issue(s4, o, x, y);
        wait_valid(s4, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk(tag, s4 ? result4 : result, exp);
        take(s4);
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        in_valid = 1'b0; op = OP_MUL; a = '0; b = '0; flush = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; op4 = OP_MUL; a4 = '0; b4 = '0; flush4 = 1'b0; out_ready4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_in_ready4", {63'd0, in_ready4}, 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // MUL with the consumer stalling for five cycles
        issue(1'b0, OP_MUL, 64'd7, -64'sd3);
        wait_valid(1'b0, lat);
        chk("mul_lat", 64'(lat), 64'd64);
        chk("mul", result, 64'hFFFF_FFFF_FFFF_FFEB);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
        end
        take(1'b0);
        chk("after_take_in_ready", {63'd0, in_ready}, 64'd1);

        run(1'b0, "mulhu",  OP_MULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64);
        run(1'b0, "mulh",   OP_MULH,   '1, '1, 64'h0, 64);
        run(1'b0, "mulhsu", OP_MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run(1'b0, "mulw",   OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32);
        run(1'b0, "div",    OP_DIV,    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64);
        run(1'b0, "rem",    OP_REM,    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run(1'b0, "divu",   OP_DIVU,   64'd100, 64'd7, 64'd14, 64);
        run(1'b0, "remu",   OP_REMU,   64'd100, 64'd7, 64'd2, 64);
        run(1'b0, "divuw",  OP_DIVUW,  64'h1_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 32);
        run(1'b0, "divw",   OP_DIVW,   64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32);

        // Fast path: divide by zero, signed overflow, illegal encoding
        run(1'b0, "div_by0",   OP_DIV,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run(1'b0, "remu_by0",  OP_REMU,  64'd5, 64'd0, 64'd5, 0);
        run(1'b0, "remuw_by0", OP_REMUW, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run(1'b0, "div_ovf",   OP_DIV,   64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0);
        run(1'b0, "remw_ovf",  OP_REMW,  64'h0000_0000_8000_0000, '1, 64'h0, 0);
        run(1'b0, "illegal",   mdu_op_t'(4'd13), 64'd9, 64'd9, 64'h0, 0);

        // flush during BUSY, then a clean MUL
        issue(1'b0, OP_DIVU, 64'd100, 64'd7);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        run(1'b0, "mul_after_flush", OP_MUL, 64'd12, 64'd11, 64'd132, 64);

        // flush alongside in_valid in IDLE blocks the accept
        in_valid = 1'b1; op = OP_MUL; a = 64'd3; b = 64'd3; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", {63'd0, busy}, 64'd0);

        // flush in DONE drops the pending result
        issue(1'b0, OP_DIV, 64'd5, 64'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_done_in_ready", {63'd0, in_ready}, 64'd1);

        // asynchronous reset between edges while BUSY
        issue(1'b0, OP_MUL, 64'd5, 64'd5);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_valid", {63'd0, out_valid}, 64'd0);
        chk("areset_busy", {63'd0, busy}, 64'd0);
        chk("areset_in_ready", {63'd0, in_ready}, 64'd1);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run(1'b0, "rem_after_reset", OP_REM, 64'd7, -64'sd2, 64'd1, 64);

        // STEP=4 latencies
        run(1'b1, "s4_mul",   OP_MUL,   64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 16);
        run(1'b1, "s4_mulhu", OP_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 16);
        run(1'b1, "s4_divw",  OP_DIVW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8);
        run(1'b1, "s4_remu",  OP_REMU,  64'd100, 64'd7, 64'd2, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
